// File: rtl/nmr_seq_pkg.sv
// Shared definitions for the CPMG pulse sequencer.
// Default widths, state encoding and small state-class helpers.
package nmr_seq_pkg;

    localparam int DEF_TW = 32;
    localparam int DEF_EW = 32;
    localparam int DEF_SW = 16;
    localparam int DEF_PW = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1P  = 3'd1,
        S_T1D  = 3'd2,
        S_P90  = 3'd3,
        S_DNA  = 3'd4,
        S_P180 = 3'd5,
        S_DACQ = 3'd6,
        S_GAP  = 3'd7
    } seq_state_t;

    function automatic logic is_rf(input seq_state_t s);
        return (s == S_T1P) || (s == S_P90) || (s == S_P180);
    endfunction

    function automatic logic is_exc(input seq_state_t s);
        return (s == S_T1P) || (s == S_P90);
    endfunction

endpackage

// File: rtl/nmr_seg_timer.sv
// Segment length timer: loadable down-counter, zero length acts as one.
// Ports: clk, rst_n, load, len (TW) in; tc (count is on its last cycle) out.
module nmr_seg_timer
    import nmr_seq_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] len,
    output logic          tc
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? TW'(1) : len;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    // The cycle holding 1 is the last cycle of the segment.
    assign tc = (cnt == TW'(1));

endmodule

// File: rtl/nmr_cpmg_sequencer.sv
// CPMG pulse-program sequencer: optional T1 prep, 90, echo train, gaps.
// Ports: clock/reset, START/ABORT, segment lengths, counts, phases; registered RF/RX/ACQ/status outputs.
module nmr_cpmg_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int TW = DEF_TW,
    parameter int EW = DEF_EW,
    parameter int SW = DEF_SW,
    parameter int PW = DEF_PW
) (
    input  logic          PULSEPROG_CLK,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          ABORT,
    input  logic          T1_EN,
    input  logic [TW-1:0] T1_PULSE180,
    input  logic [TW-1:0] T1_DELAY,
    input  logic [TW-1:0] PULSE90,
    input  logic [TW-1:0] DELAY_NO_ACQ,
    input  logic [TW-1:0] PULSE180,
    input  logic [TW-1:0] DELAY_WITH_ACQ,
    input  logic [TW-1:0] SCAN_GAP,
    input  logic [EW-1:0] ECHO_PER_SCAN,
    input  logic [SW-1:0] SAMPLES_PER_ECHO,
    input  logic [SW-1:0] ADC_INIT_DELAY,
    input  logic [SW-1:0] SCANS,
    input  logic [PW-1:0] P90_PHASE,
    input  logic [PW-1:0] P180_PHASE,
    input  logic [PW-1:0] PHASE_STEP,
    output logic          RF_GATE,
    output logic [PW-1:0] RF_PHASE,
    output logic          EN_RX,
    output logic          ACQ_EN,
    output logic [EW-1:0] ECHO_IDX,
    output logic [SW-1:0] SCAN_IDX,
    output logic          BUSY,
    output logic          DONE
);

    localparam int OW = (TW > SW + 1) ? TW : SW + 1;
    localparam logic [EW:0] EONE = 1;
    localparam logic [SW:0] SONE = 1;

    // Configuration captured at START
    logic          c_t1_en;
    logic [TW-1:0] c_t1p, c_t1d, c_p90, c_dna, c_p180, c_dacq, c_gap;
    logic [EW-1:0] c_echo;
    logic [SW-1:0] c_samp, c_adly, c_scans;
    logic [PW-1:0] c_p180_ph, c_step;

    // Sequence state
    seq_state_t    state;
    logic          armed;
    logic [EW-1:0] echo_idx;
    logic [SW-1:0] scan_idx;
    logic [PW-1:0] ph_acc;
    logic [TW-1:0] off;

    // Next-state signals
    seq_state_t    nxt;
    seq_state_t    first_st;
    logic [EW-1:0] nxt_echo;
    logic [SW-1:0] nxt_scan;
    logic [PW-1:0] nxt_ph;
    logic          nxt_done;
    logic          scan_end;
    logic          echo_more;
    logic          scan_more;
    logic          ld;
    logic [TW-1:0] ld_len;
    logic          tc;
    logic [TW-1:0] off_n;
    logic [OW-1:0] off_x, lo_x, hi_x;
    logic          acq_n;
    logic          take_start;

    assign first_st  = c_t1_en ? S_T1P : S_P90;
    assign echo_more = ({1'b0, echo_idx} + EONE) < {1'b0, c_echo};
    assign scan_more = ({1'b0, scan_idx} + SONE) < {1'b0, c_scans};
    assign take_start = (state == S_IDLE) && !armed && START && !ABORT;

    always_comb begin
        nxt      = state;
        nxt_echo = echo_idx;
        nxt_scan = scan_idx;
        nxt_ph   = ph_acc;
        nxt_done = 1'b0;
        scan_end = 1'b0;
        unique case (state)
            S_IDLE: if (armed) nxt = first_st;
            S_T1P:  if (tc) nxt = S_T1D;
            S_T1D:  if (tc) nxt = S_P90;
            S_P90:  if (tc) nxt = S_DNA;
            S_DNA: begin
                if (tc) begin
                    if (c_echo != '0) nxt = S_P180;
                    else scan_end = 1'b1;
                end
            end
            S_P180: if (tc) nxt = S_DACQ;
            S_DACQ: begin
                if (tc) begin
                    if (echo_more) begin
                        nxt      = S_P180;
                        nxt_echo = echo_idx + EW'(1);
                    end else begin
                        scan_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tc) begin
                    nxt      = first_st;
                    nxt_scan = scan_idx + SW'(1);
                    nxt_ph   = ph_acc + c_step;
                end
            end
        endcase
        if (scan_end) begin
            nxt_echo = '0;
            if (scan_more) begin
                nxt = S_GAP;
            end else begin
                nxt      = S_IDLE;
                nxt_scan = '0;
                nxt_done = 1'b1;
            end
        end
        if (ABORT && state != S_IDLE) begin
            nxt      = S_IDLE;
            nxt_echo = '0;
            nxt_scan = '0;
            nxt_done = 1'b0;
        end
    end

    // Every segment boundary is a state change, so load on change.
    assign ld = (nxt != state) && (nxt != S_IDLE);

    always_comb begin
        ld_len = '0;
        unique case (nxt)
            S_IDLE: ld_len = '0;
            S_T1P:  ld_len = c_t1p;
            S_T1D:  ld_len = c_t1d;
            S_P90:  ld_len = c_p90;
            S_DNA:  ld_len = c_dna;
            S_P180: ld_len = c_p180;
            S_DACQ: ld_len = c_dacq;
            S_GAP:  ld_len = c_gap;
        endcase
    end

    nmr_seg_timer #(.TW(TW)) u_timer (
        .clk   (PULSEPROG_CLK),
        .rst_n (RESET_N),
        .load  (ld),
        .len   (ld_len),
        .tc    (tc)
    );

    // Offset within the acquisition window; window end kept one bit wider.
    assign off_n = (state == S_DACQ) ? off + TW'(1) : '0;
    assign off_x = OW'(off_n);
    assign lo_x  = OW'(c_adly);
    assign hi_x  = OW'({1'b0, c_adly} + {1'b0, c_samp});
    assign acq_n = (nxt == S_DACQ) && (off_x >= lo_x) && (off_x < hi_x);

    always_ff @(posedge PULSEPROG_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            c_t1_en   <= 1'b0;
            c_t1p     <= '0;
            c_t1d     <= '0;
            c_p90     <= '0;
            c_dna     <= '0;
            c_p180    <= '0;
            c_dacq    <= '0;
            c_gap     <= '0;
            c_echo    <= '0;
            c_samp    <= '0;
            c_adly    <= '0;
            c_scans   <= '0;
            c_p180_ph <= '0;
            c_step    <= '0;
            state     <= S_IDLE;
            armed     <= 1'b0;
            echo_idx  <= '0;
            scan_idx  <= '0;
            ph_acc    <= '0;
            off       <= '0;
            RF_GATE   <= 1'b0;
            RF_PHASE  <= '0;
            EN_RX     <= 1'b0;
            ACQ_EN    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state    <= nxt;
            echo_idx <= nxt_echo;
            scan_idx <= nxt_scan;
            ph_acc   <= nxt_ph;
            off      <= off_n;
            armed    <= 1'b0;
            if (take_start) begin
                armed     <= 1'b1;
                c_t1_en   <= T1_EN;
                c_t1p     <= T1_PULSE180;
                c_t1d     <= T1_DELAY;
                c_p90     <= PULSE90;
                c_dna     <= DELAY_NO_ACQ;
                c_p180    <= PULSE180;
                c_dacq    <= DELAY_WITH_ACQ;
                c_gap     <= SCAN_GAP;
                c_echo    <= ECHO_PER_SCAN;
                c_samp    <= SAMPLES_PER_ECHO;
                c_adly    <= ADC_INIT_DELAY;
                c_scans   <= (SCANS == '0) ? SW'(1) : SCANS;
                c_p180_ph <= P180_PHASE;
                c_step    <= PHASE_STEP;
                ph_acc    <= P90_PHASE;
            end
            RF_GATE <= is_rf(nxt);
            if (is_exc(nxt)) RF_PHASE <= nxt_ph;
            else if (nxt == S_P180) RF_PHASE <= c_p180_ph;
            else RF_PHASE <= '0;
            EN_RX  <= (nxt == S_DACQ);
            ACQ_EN <= acq_n;
            BUSY   <= (nxt != S_IDLE);
            DONE   <= nxt_done;
        end
    end

    assign ECHO_IDX = echo_idx;
    assign SCAN_IDX = scan_idx;

endmodule

// File: tb/tb_nmr_cpmg_sequencer.sv
// Scoreboard bench for the CPMG sequencer.
// Expected output pulses are queued per signal; a monitor matches observed pulses.
module tb_nmr_cpmg_sequencer;

    localparam int TW = 32;
    localparam int EW = 32;
    localparam int SW = 16;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          RESET_N;
    logic          START, ABORT, T1_EN;
    logic [TW-1:0] T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ;
    logic [TW-1:0] PULSE180, DELAY_WITH_ACQ, SCAN_GAP;
    logic [EW-1:0] ECHO_PER_SCAN;
    logic [SW-1:0] SAMPLES_PER_ECHO, ADC_INIT_DELAY, SCANS;
    logic [PW-1:0] P90_PHASE, P180_PHASE, PHASE_STEP;
    logic          RF_GATE, EN_RX, ACQ_EN, BUSY, DONE;
    logic [PW-1:0] RF_PHASE;
    logic [EW-1:0] ECHO_IDX;
    logic [SW-1:0] SCAN_IDX;

    always #5 clk = ~clk;

    nmr_cpmg_sequencer #(.TW(TW), .EW(EW), .SW(SW), .PW(PW)) dut (
        .PULSEPROG_CLK    (clk),
        .RESET_N          (RESET_N),
        .START            (START),
        .ABORT            (ABORT),
        .T1_EN            (T1_EN),
        .T1_PULSE180      (T1_PULSE180),
        .T1_DELAY         (T1_DELAY),
        .PULSE90          (PULSE90),
        .DELAY_NO_ACQ     (DELAY_NO_ACQ),
        .PULSE180         (PULSE180),
        .DELAY_WITH_ACQ   (DELAY_WITH_ACQ),
        .SCAN_GAP         (SCAN_GAP),
        .ECHO_PER_SCAN    (ECHO_PER_SCAN),
        .SAMPLES_PER_ECHO (SAMPLES_PER_ECHO),
        .ADC_INIT_DELAY   (ADC_INIT_DELAY),
        .SCANS            (SCANS),
        .P90_PHASE        (P90_PHASE),
        .P180_PHASE       (P180_PHASE),
        .PHASE_STEP       (PHASE_STEP),
        .RF_GATE          (RF_GATE),
        .RF_PHASE         (RF_PHASE),
        .EN_RX            (EN_RX),
        .ACQ_EN           (ACQ_EN),
        .ECHO_IDX         (ECHO_IDX),
        .SCAN_IDX         (SCAN_IDX),
        .BUSY             (BUSY),
        .DONE             (DONE)
    );

    typedef struct packed {
        int st;
        int len;
        int dat;
    } seg_t;

    seg_t  q_rf[$], q_rx[$], q_acq[$], q_dn[$];
    int    checks = 0;
    int    errors = 0;
    int    ecnt = 0;
    int    t0 = 0;
    string knm[4] = '{"rf_pulse", "rx_window", "acq_window", "done_pulse"};

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic push(input int k, input int st, input int len, input int dat);
        seg_t e;
        e.st = st; e.len = len; e.dat = dat;
        case (k)
            0: q_rf.push_back(e);
            1: q_rx.push_back(e);
            2: q_acq.push_back(e);
            default: q_dn.push_back(e);
        endcase
    endtask

    task automatic score(input int k, input seg_t g);
        seg_t e;
        bit   have;
        have = 1'b0;
        e = '0;
        case (k)
            0: if (q_rf.size() > 0) begin have = 1'b1; e = q_rf.pop_front(); end
            1: if (q_rx.size() > 0) begin have = 1'b1; e = q_rx.pop_front(); end
            2: if (q_acq.size() > 0) begin have = 1'b1; e = q_acq.pop_front(); end
            default: if (q_dn.size() > 0) begin have = 1'b1; e = q_dn.pop_front(); end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected: got start=%0d len=%0d data=%0d, none expected",
                     knm[k], g.st, g.len, g.dat);
        end else if (g != e) begin
            errors++;
            $display("FAIL %s: got start=%0d len=%0d data=%0d, expected start=%0d len=%0d data=%0d",
                     knm[k], g.st, g.len, g.dat, e.st, e.len, e.dat);
        end
    endtask

    // Monitor: track pulses on each output and score each one when it ends.
    bit on[4];
    int st_c[4];
    int dat_c[4];
    initial for (int i = 0; i < 4; i++) begin on[i] = 1'b0; st_c[i] = 0; dat_c[i] = 0; end

    always @(negedge clk) begin
        int   cyc;
        bit   s[4];
        int   d[4];
        seg_t g;
        cyc = ecnt - t0;
        s[0] = RF_GATE; d[0] = int'(RF_PHASE);
        s[1] = EN_RX;   d[1] = int'(ECHO_IDX) + 16 * int'(SCAN_IDX);
        s[2] = ACQ_EN;  d[2] = d[1];
        s[3] = DONE;    d[3] = 0;
        for (int k = 0; k < 4; k++) begin
            if (on[k] && (!s[k] || d[k] != dat_c[k])) begin
                g.st = st_c[k]; g.len = cyc - st_c[k]; g.dat = dat_c[k];
                score(k, g);
                on[k] = 1'b0;
            end
            if (s[k] && !on[k]) begin
                on[k] = 1'b1; st_c[k] = cyc; dat_c[k] = d[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic expect_empty(input string nm);
        int left;
        left = q_rf.size() + q_rx.size() + q_acq.size() + q_dn.size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL %s missing pulses: got %0d outstanding expected 0", nm, left);
        end
        q_rf.delete(); q_rx.delete(); q_acq.delete(); q_dn.delete();
    endtask

    task automatic go();
        START = 1'b1;
        @(posedge clk);
        #1 t0 = ecnt;
        START = 1'b0;
    endtask

    task automatic cfg_base();
        T1_EN = 1'b0; T1_PULSE180 = 0; T1_DELAY = 0;
        PULSE90 = 4; DELAY_NO_ACQ = 6; PULSE180 = 3; DELAY_WITH_ACQ = 10;
        SCAN_GAP = 0; ECHO_PER_SCAN = 2; SCANS = 1;
        ADC_INIT_DELAY = 0; SAMPLES_PER_ECHO = 0;
        P90_PHASE = 1; P180_PHASE = 3; PHASE_STEP = 0;
    endtask

    task automatic exp_base();
        push(0, 1, 4, 1); push(0, 11, 3, 3); push(0, 24, 3, 3);
        push(1, 14, 10, 0); push(1, 27, 10, 1);
        push(3, 37, 1, 0);
    endtask

    initial begin
        START = 1'b0; ABORT = 1'b0; RESET_N = 1'b0;
        cfg_base();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_gate", RF_GATE, 0);
        chk("rst_rf_phase", RF_PHASE, 0);
        chk("rst_en_rx", EN_RX, 0);
        chk("rst_acq_en", ACQ_EN, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_idx", {ECHO_IDX, SCAN_IDX}, 0);
        RESET_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic echo train; mid-run START and input changes are ignored
        exp_base();
        go();
        repeat (4) @(posedge clk);
        #1 START = 1'b1; PULSE90 = 9; ECHO_PER_SCAN = 5;
        chk("busy_running", BUSY, 1);
        @(posedge clk);
        #1 START = 1'b0;
        repeat (42) @(posedge clk);
        #1 expect_empty("basic");
        cfg_base();

        // ADC window inside DACQ
        ADC_INIT_DELAY = 2; SAMPLES_PER_ECHO = 5;
        exp_base();
        push(2, 16, 5, 0); push(2, 29, 5, 1);
        go();
        repeat (45) @(posedge clk);
        #1 expect_empty("acq_window");

        // ADC window clipped at DACQ end
        SAMPLES_PER_ECHO = 20;
        exp_base();
        push(2, 16, 8, 0); push(2, 29, 8, 1);
        go();
        repeat (45) @(posedge clk);
        #1 expect_empty("acq_clip");
        cfg_base();

        // T1 prep, three scans, phase cycling, gaps
        T1_EN = 1'b1; T1_PULSE180 = 2; T1_DELAY = 3;
        SCANS = 3; SCAN_GAP = 5; P90_PHASE = 0; PHASE_STEP = 2; P180_PHASE = 1;
        for (int s = 0; s < 3; s++) begin
            int b;
            int ph;
            b = 1 + 46 * s;
            ph = (2 * s) % 4;
            push(0, b, 2, ph); push(0, b + 5, 4, ph);
            push(0, b + 15, 3, 1); push(0, b + 28, 3, 1);
            push(1, b + 18, 10, 16 * s); push(1, b + 31, 10, 16 * s + 1);
        end
        push(3, 134, 1, 0);
        go();
        repeat (150) @(posedge clk);
        #1 expect_empty("multi_scan");
        cfg_base();

        // Abort mid-P180, then restart
        push(0, 1, 4, 1); push(0, 11, 2, 3);
        go();
        repeat (12) @(posedge clk);
        #1 ABORT = 1'b1;
        @(posedge clk);
        #1 ABORT = 1'b0;
        chk("abort_rf_gate", RF_GATE, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_en_rx", EN_RX, 0);
        repeat (6) @(posedge clk);
        #1 expect_empty("abort");
        exp_base();
        go();
        repeat (45) @(posedge clk);
        #1 expect_empty("restart");

        // START together with ABORT in IDLE does not start
        ABORT = 1'b1; START = 1'b1;
        @(posedge clk);
        #1 ABORT = 1'b0; START = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("start_abort_busy", BUSY, 0);
        chk("start_abort_rf", RF_GATE, 0);

        // Asynchronous reset mid-P180
        push(0, 1, 4, 1); push(0, 11, 1, 3);
        go();
        repeat (12) @(posedge clk);
        #2 RESET_N = 1'b0;
        #1;
        chk("areset_rf_gate", RF_GATE, 0);
        chk("areset_rf_phase", RF_PHASE, 0);
        chk("areset_busy", BUSY, 0);
        chk("areset_en_rx", EN_RX, 0);
        #20 RESET_N = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("areset_no_restart", BUSY, 0);
        expect_empty("async_reset");

        // All lengths zero, no echoes, zero scans
        T1_EN = 1'b0; T1_PULSE180 = 0; T1_DELAY = 0;
        PULSE90 = 0; DELAY_NO_ACQ = 0; PULSE180 = 0; DELAY_WITH_ACQ = 0;
        SCAN_GAP = 0; ECHO_PER_SCAN = 0; SCANS = 0; P90_PHASE = 2;
        push(0, 1, 1, 2);
        push(3, 3, 1, 0);
        go();
        @(posedge clk);
        #1 chk("zero_busy_c1", BUSY, 1);
        @(posedge clk);
        #1 chk("zero_busy_c2", BUSY, 1);
        repeat (8) @(posedge clk);
        #1 expect_empty("zero_lengths");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
